uart_rx: RTL

UART receiver, the counterpart of the existing uart_out transmitter.
- Deserialises 8N1 frames from the serial pin (1 start bit, WORDSIZE data bits LSB first, 1 stop bit, no parity) at BIT_SIZE clocks per bit.
- Presents each byte with a one-cycle done strobe.
- Feeds the Intel-HEX programming loader; uart_out carries ACK/NAK back to the host.

---
 rtl/uart_rx_pkg.sv | 17 +
 rtl/uart_rx_sync.sv | 21 ++
 rtl/up_counter.sv | 20 ++
 rtl/uart_rx.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared constants, widths and FSM state encoding for the UART receiver.
package uart_rx_pkg;

  localparam int unsigned BIT_SIZE_DEFAULT = 10415;
  localparam int unsigned WORDSIZE_DEFAULT = 8;
  localparam int unsigned CYC_W            = 32;
  localparam int unsigned BCNT_W           = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to idle-high.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      meta <= rx;
      rx_s <= meta;
    end
  end

endmodule

// File: rtl/up_counter.sv
// Free-running up counter with synchronous clear (clear wins over enable).
module up_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle done / framing-error strobes.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned BIT_SIZE = BIT_SIZE_DEFAULT,
  parameter int unsigned WORDSIZE = WORDSIZE_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx,
  output logic [WORDSIZE-1:0] data_out,
  output logic                rx_done,
  output logic                frame_err,
  output logic                busy
);

  localparam int unsigned HALF_BIT = BIT_SIZE / 2;

  rx_state_t           state;
  rx_state_t           state_nxt;
  logic                rx_s;
  logic [CYC_W-1:0]    cyc;
  logic [BCNT_W-1:0]   bcnt;
  logic [WORDSIZE-1:0] shreg;

  logic cyc_en_c;
  logic cyc_clr_c;
  logic bcnt_en_c;
  logic bcnt_clr_c;
  logic shift_c;
  logic done_c;
  logic ferr_c;
  logic half_hit_c;
  logic bit_hit_c;
  logic last_bit_c;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .rx_s (rx_s)
  );

  up_counter #(.WIDTH(CYC_W)) u_cyc (
    .clk   (clk),
    .rst   (rst),
    .en    (cyc_en_c),
    .clr   (cyc_clr_c),
    .count (cyc)
  );

  up_counter #(.WIDTH(BCNT_W)) u_bcnt (
    .clk   (clk),
    .rst   (rst),
    .en    (bcnt_en_c),
    .clr   (bcnt_clr_c),
    .count (bcnt)
  );

  // >= compares so a corrupted counter still terminates the current phase
  assign half_hit_c = (cyc >= CYC_W'(HALF_BIT - 1));
  assign bit_hit_c  = (cyc >= CYC_W'(BIT_SIZE - 1));
  assign last_bit_c = ((5'(bcnt) + 5'd1) >= 5'(WORDSIZE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cyc_en_c   = 1'b0;
    cyc_clr_c  = 1'b0;
    bcnt_en_c  = 1'b0;
    bcnt_clr_c = 1'b0;
    shift_c    = 1'b0;
    done_c     = 1'b0;
    ferr_c     = 1'b0;
    case (state)
      IDLE: begin
        cyc_clr_c  = 1'b1;
        bcnt_clr_c = 1'b1;
        if (!rx_s) begin
          state_nxt = START;
        end
      end
      START: begin
        cyc_en_c = 1'b1;
        if (half_hit_c) begin
          cyc_clr_c = 1'b1;
          state_nxt = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        cyc_en_c = 1'b1;
        if (bit_hit_c) begin
          cyc_clr_c = 1'b1;
          shift_c   = 1'b1;
          bcnt_en_c = 1'b1;
          if (last_bit_c) begin
            state_nxt = STOP;
          end
        end
      end
      STOP: begin
        cyc_en_c = 1'b1;
        // leaving at mid stop bit gives half a bit of slack for the next start edge
        if (bit_hit_c) begin
          cyc_clr_c = 1'b1;
          if (rx_s) begin
            done_c    = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr_c    = 1'b1;
            state_nxt = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        cyc_clr_c = 1'b1;
        if (rx_s) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        cyc_clr_c = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  // Shift register (LSB first) and registered strobes / status
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg     <= '0;
      data_out  <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rx_done   <= done_c;
      frame_err <= ferr_c;
      busy      <= (state_nxt != IDLE);
      if (shift_c) begin
        shreg <= {rx_s, shreg[WORDSIZE-1:1]};
      end
      if (done_c) begin
        data_out <= shreg;
      end
    end
  end

endmodule
